conv_window_sequencer: RTL and testbench

//  Sequences the single-port image RAM (input image + output region) for the 3x3 convolution accelerator.
//  For each valid output position: fetches a 3x3 pixel window over the shared port, hands it to the conv datapath
//  (valid/ready), accepts the result (valid/ready), and writes it back to the output region. Sole RAM master.

---
 rtl/conv_pkg.sv | 9 +
 rtl/conv_addr_gen.sv | 61 ++++++
 rtl/conv_window_sequencer.sv | 81 ++++++++
 tb/tb_conv_window_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the 3x3 convolution window sequencer
package conv_pkg;
  localparam int KSIZE = 3;
  localparam int WIN_PIX = KSIZE * KSIZE;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [WIN_PIX-1:0] window_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PRESENT, S_WAIT_RES, S_WRITE, S_DONE} seq_state_e;
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: window origin counters, fetch indices and RAM addresses (column reuse when CONV_WIN_REUSE_EN)
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int N = 11,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int IN_BASE = 0,
  parameter int OUT_BASE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic         advance,
  output logic [1:0]   fr,
  output logic [1:0]   fc,
  output logic [N-1:0] rd_adr,
  output logic [N-1:0] wr_adr,
  output logic         fetch_last,
  output logic         last_col,
  output logic         last_frame
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  logic [RW-1:0] row0;
  logic [CW-1:0] col0;
  logic [1:0] fc_first, fc_after;
  if (IMG_W < KSIZE || IMG_H < KSIZE || IN_BASE + IMG_W * IMG_H > 2 ** N ||
      OUT_BASE + (IMG_W - 2) * (IMG_H - 2) > 2 ** N) begin : g_bad_params
    $error("conv_addr_gen: image or output region does not fit the RAM");
  end
`ifdef CONV_WIN_REUSE_EN
  assign fc_first = (col0 != '0) ? 2'd2 : 2'd0;
  assign fc_after = last_col ? 2'd0 : 2'd2;
`else
  assign fc_first = 2'd0;
  assign fc_after = 2'd0;
`endif
  assign last_col = col0 == CW'(IMG_W - 3);
  assign last_frame = last_col && row0 == RW'(IMG_H - 3);
  assign fetch_last = fr == 2'd2 && fc == 2'd2;
  assign rd_adr = N'(IN_BASE) + (N'(row0) + N'(fr)) * N'(IMG_W) + N'(col0) + N'(fc);
  assign wr_adr = N'(OUT_BASE) + N'(row0) * N'(IMG_W - 2) + N'(col0);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row0 <= '0;
      col0 <= '0;
      fr <= '0;
      fc <= '0;
    end else if (advance) begin
      col0 <= last_col ? '0 : col0 + 1'b1;
      row0 <= last_col ? row0 + 1'b1 : row0;
      fr <= '0;
      fc <= fc_after;
    end else if (step) begin
      fc <= (fc == 2'd2) ? fc_first : fc + 1'b1;
      fr <= (fc == 2'd2) ? fr + 1'b1 : fr;
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: sole RAM master fetching 3x3 windows and writing results back (CONV_WIN_REUSE_EN shifts windows)
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int N = 11,
  parameter int M = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int IN_BASE = 0,
  parameter int OUT_BASE = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               ram_we,
  output logic [N-1:0]       ram_adr,
  output logic [M-1:0]       ram_din,
  input  logic [M-1:0]       ram_dout,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [WIN_PIX*M-1:0] win_data,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [M-1:0]       res_data
);
  seq_state_e state;
  logic [WIN_PIX-1:0][M-1:0] win;
  logic [M-1:0] res_q;
  logic [1:0] fr, fc;
  logic [3:0] idx;
  logic [N-1:0] rd_adr, wr_adr;
  logic fetch_last, last_col, last_frame;
  conv_addr_gen #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)) u_addr (
    .clk(clk), .rst(rst), .clear(state == S_IDLE), .step(state == S_FETCH), .advance(state == S_WRITE),
    .fr(fr), .fc(fc), .rd_adr(rd_adr), .wr_adr(wr_adr),
    .fetch_last(fetch_last), .last_col(last_col), .last_frame(last_frame)
  );
  assign idx = 4'(fr) * 4'(KSIZE) + 4'(fc);
  assign busy = state != S_IDLE && state != S_DONE;
  assign done = state == S_DONE;
  assign win_valid = state == S_PRESENT;
  assign res_ready = state == S_WAIT_RES;
  assign ram_we = state == S_WRITE;
  assign ram_adr = ram_we ? wr_adr : (state == S_FETCH) ? rd_adr : '0;
  assign ram_din = ram_we ? res_q : '0;
  assign win_data = win;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      win <= '0;
      res_q <= '0;
    end else begin
      case (state)
        S_IDLE: state <= start ? S_FETCH : S_IDLE;
        S_FETCH: begin
          win[idx] <= ram_dout;
          state <= fetch_last ? S_PRESENT : S_FETCH;
        end
        S_PRESENT: state <= win_ready ? S_WAIT_RES : S_PRESENT;
        S_WAIT_RES: begin
          res_q <= res_valid ? res_data : res_q;
          state <= res_valid ? S_WRITE : S_WAIT_RES;
        end
        S_WRITE: begin
          state <= last_frame ? S_DONE : S_FETCH;
`ifdef CONV_WIN_REUSE_EN
          // Next window in the same row overlaps by two columns; only column 2 is refetched
          if (!last_col)
            for (int r = 0; r < KSIZE; r++) begin
              win[KSIZE*r] <= win[KSIZE*r+1];
              win[KSIZE*r+1] <= win[KSIZE*r+2];
            end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: directed bench with ramp image, centre-tap datapath and RAM model
module tb_conv_window_sequencer;
`ifdef CONV_WIN_REUSE_EN
  localparam int FETCH_PER_FRAME = 96 * 30;
`else
  localparam int FETCH_PER_FRAME = 270 * 30;
`endif
  localparam logic [71:0] WIN0 = 72'h42_41_40_22_21_20_02_01_00;
  logic clk = 0, rst = 1, start = 0, win_ready = 0, res_valid = 0;
  logic busy, done, ram_we, win_valid, res_ready;
  logic [10:0] ram_adr;
  logic [7:0] ram_din, ram_dout, res_data, cen;
  logic [71:0] win_data;
  logic [7:0] mem [0:2047];
  logic [10:0] log_adr [0:4095];
  logic [7:0] log_dat [0:4095];
  int wr_cnt = 0, done_cnt = 0, fetch_cnt = 0;
  int vec = 0, bad = 0;
  conv_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );
  always #5 clk = ~clk;
  assign ram_dout = mem[ram_adr];
  assign res_data = cen;
  always @(posedge clk) if (ram_we) mem[ram_adr] <= ram_din;
  always @(posedge clk) if (win_valid && win_ready) cen <= win_data[39:32];
  always @(negedge clk)
    if (!rst) begin
      if (ram_we) begin
        log_adr[wr_cnt] <= ram_adr;
        log_dat[wr_cnt] <= ram_din;
        wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy && !ram_we && !win_valid && !res_ready) fetch_cnt <= fetch_cnt + 1;
    end

  function automatic int frame_errors(input int w0);
    int e = 0;
    for (int k = 0; k < 900; k++)
      if (log_adr[w0+k] !== 11'(1024 + k) || log_dat[w0+k] !== 8'(((k / 30) + 1) * 32 + (k % 30) + 1)) e++;
    return e;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(posedge clk); #1;
      if (done) ok = 1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vec++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    vec++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b expected 0", ram_we); end
    vec++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid: got %0b expected 0", win_valid); end
    vec++; if (res_ready !== 1'b0) begin bad++; $display("FAIL reset_res_ready: got %0b expected 0", res_ready); end
    vec++; if (ram_adr !== 11'd0) begin bad++; $display("FAIL reset_adr: got %0h expected 0", ram_adr); end
    vec++; if (win_data !== 72'd0) begin bad++; $display("FAIL reset_win_data: got %0h expected 0", win_data); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_window_stall;
    int w0 = wr_cnt, d0 = done_cnt, f0 = fetch_cnt, e;
    bit ok;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    vec++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %0b expected 1", busy); end
    repeat (8) @(posedge clk);
    #1;
    vec++; if (win_valid !== 1'b0) begin bad++; $display("FAIL win_valid_early: got %0b expected 0", win_valid); end
    @(posedge clk); #1;
    vec++; if (win_valid !== 1'b1) begin bad++; $display("FAIL win_valid_10: got %0b expected 1", win_valid); end
    vec++; if (win_data !== WIN0) begin bad++; $display("FAIL window0: got %h expected %h", win_data, WIN0); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vec++;
      if (win_data !== WIN0 || win_valid !== 1'b1 || ram_we !== 1'b0) begin
        bad++; $display("FAIL win_stall_%0d: got data %h valid %0b we %0b expected data %h valid 1 we 0", i, win_data, win_valid, ram_we, WIN0);
      end
    end
    win_ready = 1;
    @(posedge clk); #1;
    win_ready = 0;
    for (int i = 0; i < 15; i++) begin
      vec++;
      if (res_ready !== 1'b1 || ram_we !== 1'b0) begin
        bad++; $display("FAIL res_stall_%0d: got res_ready %0b we %0b expected 1 and 0", i, res_ready, ram_we);
      end
      @(posedge clk); #1;
    end
    res_valid = 1;
    @(posedge clk); #1;
    vec++; if (ram_we !== 1'b1) begin bad++; $display("FAIL first_write_we: got %0b expected 1", ram_we); end
    vec++; if (ram_adr !== 11'd1024) begin bad++; $display("FAIL first_write_adr: got %0d expected 1024", ram_adr); end
    vec++; if (ram_din !== 8'd33) begin bad++; $display("FAIL first_write_data: got %0d expected 33", ram_din); end
    win_ready = 1;
    wait_done(ok);
    vec++; if (!ok) begin bad++; $display("FAIL frame1_timeout: got no done expected done"); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL frame1_idle: got busy %0b expected 0", busy); end
    vec++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL frame1_done_count: got %0d expected 1", done_cnt - d0); end
    vec++; if (wr_cnt - w0 !== 900) begin bad++; $display("FAIL frame1_writes: got %0d expected 900", wr_cnt - w0); end
    e = frame_errors(w0);
    vec++; if (e !== 0) begin bad++; $display("FAIL frame1_data: got %0d bad writes expected 0", e); end
    vec++; if (fetch_cnt - f0 !== FETCH_PER_FRAME) begin bad++; $display("FAIL frame1_fetch_cycles: got %0d expected %0d", fetch_cnt - f0, FETCH_PER_FRAME); end
  endtask

  task automatic test_start_ignored;
    int w0 = wr_cnt, d0 = done_cnt, e;
    bit seen = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      if (i == 5 || i == 57 || i == 600) start = 1;
      @(posedge clk); #1;
      start = 0;
      if (done) begin
        seen = 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
      end
    end
    vec++; if (!seen) begin bad++; $display("FAIL frame2_timeout: got no done expected done"); end
    repeat (5) begin
      @(posedge clk); #1;
      vec++; if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done: got busy %0b expected 0", busy); end
    end
    vec++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL frame2_done_count: got %0d expected 1", done_cnt - d0); end
    vec++; if (wr_cnt - w0 !== 900) begin bad++; $display("FAIL frame2_writes: got %0d expected 900", wr_cnt - w0); end
    e = frame_errors(w0);
    vec++; if (e !== 0) begin bad++; $display("FAIL frame2_data: got %0d bad writes expected 0", e); end
  endtask

  task automatic test_reset_mid_frame;
    int w0 = wr_cnt, w1, d1, e;
    bit hit = 0, ok;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(posedge clk); #1;
      if (ram_we && wr_cnt - w0 == 100) hit = 1;
    end
    vec++; if (!hit) begin bad++; $display("FAIL mid_reach_100: got no write 100 expected write 100"); end
    vec++; if (ram_adr !== 11'd1124) begin bad++; $display("FAIL mid_adr_100: got %0d expected 1124", ram_adr); end
    rst = 1;
    @(posedge clk); #1;
    vec++; if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %0b expected 0", ram_we); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
    vec++; if (win_valid !== 1'b0 || res_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_hs: got valid %0b ready %0b expected 0 0", win_valid, res_ready); end
    rst = 0;
    @(posedge clk); #1;
    w1 = wr_cnt; d1 = done_cnt;
    vec++; if (w1 - w0 !== 100) begin bad++; $display("FAIL mid_writes: got %0d expected 100", w1 - w0); end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    vec++; if (ram_adr !== 11'd0 || ram_we !== 1'b0) begin bad++; $display("FAIL restart_adr: got %0d we %0b expected 0 0", ram_adr, ram_we); end
    wait_done(ok);
    vec++; if (!ok) begin bad++; $display("FAIL frame3_timeout: got no done expected done"); end
    vec++; if (done_cnt - d1 !== 1) begin bad++; $display("FAIL frame3_done_count: got %0d expected 1", done_cnt - d1); end
    vec++; if (wr_cnt - w1 !== 900) begin bad++; $display("FAIL frame3_writes: got %0d expected 900", wr_cnt - w1); end
    e = frame_errors(w1);
    vec++; if (e !== 0) begin bad++; $display("FAIL frame3_data: got %0d bad writes expected 0", e); end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = (a < 1024) ? 8'(a) : 8'd0;
    test_reset;
    test_window_stall;
    test_start_ignored;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
